systolic_skew_feeder: RTL
=========================

// Module: systolic_skew_feeder
// PURPOSE
//  Upstream stage of the per-PE backpressure skid chain. Accepts one full row per beat (all COLS lanes)
//  from the operand buffer and emits it diagonally skewed: lane j is delayed j beats.
//  Output is a per-column valid mask plus lane data, in the form the skid chain indexes by PE_ID.
//  Tile boundaries are tracked by s_last. Bubbles (zero data, zero valid) are inserted whenever input is absent.
// PARAMETERS
//  COLS    16  number of array columns / lanes; width of o_valid
//  ELEM_W  8   bits per lane element; data buses are COLS*ELEM_W wide
// PORTS
//  clk      in   1            clock
//  rst_n    in   1            asynchronous active-low reset
//  s_data   in   COLS*ELEM_W  input row; lane j = s_data[j*ELEM_W +: ELEM_W]
//  s_valid  in   1            input row valid
//  s_last   in   1            marks the last row of a tile; qualified by s_valid&s_ready
//  s_ready  out  1            row accepted when s_valid&s_ready
//  o_data   out  COLS*ELEM_W  skewed lane data; a lane whose valid bit is 0 carries 0
//  o_valid  out  COLS         per-column valid mask; bit j = lane j holds a real element
//  o_last   out  1            high on the beat where lane COLS-1 carries the tile's last row
//  i_ready  in   1            downstream ready
//  o_busy   out  1            high when any row element is in flight or state != IDLE
// BEHAVIOUR
//  Interface: one clock (clk); asynchronous active-low reset (rst_n).
//  Reset: o_data=0, o_valid=0, o_last=0, all lane chains and masks cleared, state=IDLE.
//    s_ready=0 while in reset. Reset mid-tile discards everything in flight; there is no partial flush.
//  Advance: adv = (o_valid==0) | i_ready. While adv=0, every register holds (o_valid/o_data/o_last stable).
//  On adv:
//    lane0 stage <= accepted ? s_data lane0 : 0
//    lane j stage k <= stage k-1 (chain depth j for lane j; total COLS*(COLS-1)/2 elements)
//    mask <= {mask[COLS-2:0], accepted}; o_valid <= new mask; lanes with mask bit 0 driven 0
//    last-chain (COLS bits) shifts the same way with accepted&s_last
//  Latency: row accepted at edge N -> lane j appears on the output after j+1 advances; no bubbles when i_ready=1.
//  s_ready = adv & (state!=DRAIN); combinational on i_ready; no combinational path from s_valid.
//    With s_valid=0 during adv, a bubble (accepted=0) is shifted in.
//  FSM:
//    IDLE -> STREAM on the first accepted row
//    STREAM -> DRAIN when a row is accepted with s_last=1 (drain counter := COLS-1)
//    DRAIN: counter decrements per adv; at 0 -> IDLE
//    DRAIN -> IDLE directly when COLS=1
//  Single-row tile (s_last on first row): IDLE -> DRAIN directly.
//  o_last: driven from the last-chain tap COLS-1; coincides with o_valid[COLS-1]=1.
//  o_busy = (state!=IDLE) | (|mask).
//  Simultaneous events: in DRAIN with i_ready=1, counter decrement and the shift occur on the same edge.
// CONFIGURATION
//  SKEW_BACK2BACK_EN undefined (default):
//    s_ready=0 in DRAIN; the next tile's row 0 enters only after the previous tile fully exits lane COLS-1,
//    so tiles never overlap in the array.
//  SKEW_BACK2BACK_EN defined:
//    s_ready = adv in all states; a row accepted in DRAIN starts the next tile (DRAIN -> STREAM, counter reloads
//    if that row has s_last). Tiles overlap diagonally; o_last marks each tile's end independently.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately (async); after release, s_ready=1 next cycle,
//    o_busy=0.
//  2 COLS=4, 4 rows back-to-back, i_ready=1, rows r=0..3 lane j = 16*r+j ->
//    o_valid sequence 0001,0011,0111,1111,1110,1100,1000,0000; lane j shows r=k-j; o_last with o_valid=1000.
//  3 Same tile, i_ready=0 for 3 cycles when o_valid=0111 -> outputs frozen 3 cycles, s_ready=0,
//    sequence resumes unchanged.
//  4 s_valid gap of 1 cycle after row 1 -> zero-diagonal: o_valid 0001,0011,0110,1101,... with zero data in gaps.
//  5 Default build, s_valid held high across two tiles -> s_ready=0 for 3 adv cycles after s_last;
//    tile-2 row 0 appears only after o_valid=1000.
//  6 SKEW_BACK2BACK_EN, same stimulus -> no s_ready gap; o_valid=1111 continuous; two o_last pulses 4 beats apart.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder: one full row in per beat, lane j leaves j+1 advances later.
// Latency lane j = j+1 advances; on i_ready=0 with any lane valid everything holds and s_ready drops.
// Optional SKEW_BACK2BACK_EN: accept the next tile while the previous one drains (diagonal overlap).
module systolic_skew_feeder #(
    parameter int COLS   = 16,
    parameter int ELEM_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COLS*ELEM_W-1:0] s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [COLS*ELEM_W-1:0] o_data,
    output logic [COLS-1:0]        o_valid,
    output logic                   o_last,
    input  logic                   i_ready,
    output logic                   o_busy
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    localparam int            CW         = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(COLS - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [COLS-1:0] mask;
    logic [COLS-1:0] last_sr;
    logic            adv;
    logic            accepted;

    assign adv = (mask == '0) | i_ready;

`ifdef SKEW_BACK2BACK_EN
    assign s_ready = rst_n & adv;
`else
    assign s_ready = rst_n & adv & (state != DRAIN);
`endif

    assign accepted = s_valid & s_ready;

    // A fresh accept always wins over draining, so back-to-back tiles reload the counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (adv) begin
            if (accepted) begin
                if (s_last) begin
                    state_nxt = (COLS == 1) ? IDLE : DRAIN;
                    cnt_nxt   = DRAIN_LOAD;
                end else begin
                    state_nxt = STREAM;
                end
            end else if (state == DRAIN) begin
                if (cnt <= CW'(1)) begin
                    state_nxt = IDLE;
                end
                cnt_nxt = (cnt == '0) ? '0 : cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mask    <= '0;
            last_sr <= '0;
        end else if (adv) begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mask    <= (mask << 1) | COLS'(accepted);
            last_sr <= (last_sr << 1) | COLS'(accepted & s_last);
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_lane
        // Element j+1 deep delay line; the final entry is the registered output.
        logic [ELEM_W-1:0] sr [j+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= j; k++) begin
                    sr[k] <= '0;
                end
            end else if (adv) begin
                sr[0] <= accepted ? s_data[j*ELEM_W +: ELEM_W] : '0;
                for (int k = 1; k <= j; k++) begin
                    sr[k] <= sr[k-1];
                end
            end
        end

        assign o_data[j*ELEM_W +: ELEM_W] = sr[j];
    end

    assign o_valid = mask;
    assign o_last  = last_sr[COLS-1];
    assign o_busy  = (state != IDLE) | (|mask);

endmodule
